// File: rtl/present_enc_ctrl.sv
// Iterative PRESENT-80 encryption controller: one round per clock, key schedule computed on the fly.
// Also holds the S-box and bit-permutation primitives used by the datapath.
module present_enc_ctrl #(
    parameter int NUM_ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] plaintext,
    input  logic [79:0] key,
    output logic        busy,
    output logic [63:0] ciphertext,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam logic [4:0] LAST_ROUND = NUM_ROUNDS[4:0];

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} fsm_t;

    fsm_t        fsm_reg, fsm_next;
    logic [63:0] state_reg, state_next;
    logic [79:0] key_reg, key_next;
    logic [4:0]  round_ctr, round_ctr_next;
    logic [63:0] ciphertext_reg, ciphertext_next;
    logic        out_valid_reg, out_valid_next;

    logic [63:0] round_in;
    logic [63:0] sbox_out;
    logic [63:0] perm_out;
    logic [79:0] key_rot;
    logic [3:0]  key_sbox;
    logic [79:0] key_upd;

    // addRoundKey -> sBoxLayer -> pLayer
    assign round_in = state_reg ^ key_reg[79:16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
            S_box_enc u_sbox (
                .din  (round_in[4*gi +: 4]),
                .dout (sbox_out[4*gi +: 4])
            );
        end
    endgenerate

    player_enc u_player (
        .din  (sbox_out),
        .dout (perm_out)
    );

    // Key update: rotate left 61, S-box the top nibble, fold in the round counter
    assign key_rot = {key_reg[18:0], key_reg[79:19]};

    S_box_enc u_key_sbox (
        .din  (key_rot[79:76]),
        .dout (key_sbox)
    );

    assign key_upd = {key_sbox, key_rot[75:20], key_rot[19:15] ^ round_ctr, key_rot[14:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg        <= IDLE;
            state_reg      <= '0;
            key_reg        <= '0;
            round_ctr      <= '0;
            ciphertext_reg <= '0;
            out_valid_reg  <= 1'b0;
        end else begin
            fsm_reg        <= fsm_next;
            state_reg      <= state_next;
            key_reg        <= key_next;
            round_ctr      <= round_ctr_next;
            ciphertext_reg <= ciphertext_next;
            out_valid_reg  <= out_valid_next;
        end
    end

    always_comb begin
        fsm_next        = fsm_reg;
        state_next      = state_reg;
        key_next        = key_reg;
        round_ctr_next  = round_ctr;
        ciphertext_next = ciphertext_reg;
        out_valid_next  = out_valid_reg;
        case (fsm_reg)
            IDLE: begin
                if (start) begin
                    state_next     = plaintext;
                    key_next       = key;
                    round_ctr_next = 5'd1;
                    fsm_next       = ROUND;
                end
            end
            ROUND: begin
                state_next = perm_out;
                key_next   = key_upd;
                // The counter stops at the last round so it never wraps.
                if (round_ctr == LAST_ROUND) begin
                    fsm_next = FINAL;
                end else begin
                    round_ctr_next = round_ctr + 5'd1;
                end
            end
            FINAL: begin
                ciphertext_next = state_reg ^ key_reg[79:16];
                out_valid_next  = 1'b1;
                fsm_next        = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    fsm_next       = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    assign busy       = (fsm_reg != IDLE);
    assign ciphertext = ciphertext_reg;
    assign out_valid  = out_valid_reg;
endmodule

// PRESENT 4-bit S-box.
module S_box_enc (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        case (din)
            4'h0: dout = 4'hC;
            4'h1: dout = 4'h5;
            4'h2: dout = 4'h6;
            4'h3: dout = 4'hB;
            4'h4: dout = 4'h9;
            4'h5: dout = 4'h0;
            4'h6: dout = 4'hA;
            4'h7: dout = 4'hD;
            4'h8: dout = 4'h3;
            4'h9: dout = 4'hE;
            4'hA: dout = 4'hF;
            4'hB: dout = 4'h8;
            4'hC: dout = 4'h4;
            4'hD: dout = 4'h7;
            4'hE: dout = 4'h1;
            default: dout = 4'h2;
        endcase
    end
endmodule

// PRESENT bit permutation: bit i moves to 16*i mod 63, bit 63 stays put.
module player_enc (
    input  logic [63:0] din,
    output logic [63:0] dout
);
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_perm
            localparam int DST = (gi == 63) ? 63 : ((gi * 16) % 63);
            assign dout[DST] = din[gi];
        end
    endgenerate
endmodule
